// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if
// Groups the core request/response handshake and the SRAM IO controller bus
// used by mem_req_ctrl.
//   slave  : view taken by mem_req_ctrl (accepts core requests, drives bus strobes)
//   master : view taken by the environment (core + SRAM IO controller)
// Signals:
//   req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata : core request
//   resp_valid, resp_rdata, resp_err                                        : core response
//   mem_read, mem_write, mem_addr, mem_write_data, mem_ack, mem_read_data   : SRAM IO bus
interface mem_req_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_write_data
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// Converts single core load/store requests (byte/half/word, big-endian lanes)
// into word-wide SRAM bus transactions. Sub-word stores are done as
// read-modify-write. Misaligned or illegal-size requests and bus timeouts
// complete with resp_err.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_req_ctrl_if.slave (request, response and SRAM bus signals)
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1)
// RD    | mem_read strobe active: load, or read half of a sub-word store
// WR    | mem_write strobe active: word store, or write half of a sub-word store
// RESP  | one-cycle resp_valid pulse
module mem_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_req_ctrl_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t        state, state_next;
  logic          ready_c, resp_valid_c;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic          req_bad;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [1:0]    r_off;
  logic [15:0]   r_wlo;

  logic          mem_read_q, mem_write_q;
  logic [31:0]   mem_addr_q, mem_write_data_q;
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic [4:0]    byte_lsb, half_lsb;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data, store_merge;

  assign req_bad = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Strobe is visible for exactly TIMEOUT_CYCLES cycles; an ack landing in
  // the last of them is ignored because timeout is tested first.
  assign timeout = (state == RD || state == WR) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    ready_c      = 1'b0;
    resp_valid_c = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          if (req_bad)                                   state_next = RESP;
          else if (bus.req_we && bus.req_size == 2'b10)  state_next = WR;
          else                                           state_next = RD;
        end
      end
      RD: begin
        if (timeout)          state_next = RESP;
        else if (bus.mem_ack) state_next = r_we ? WR : RESP;
      end
      WR: begin
        if (timeout || bus.mem_ack) state_next = RESP;
      end
      RESP: begin
        resp_valid_c = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change, so RD->WR gets a fresh budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state_next != state || (state != RD && state != WR))
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  assign byte_lsb = {~r_off, 3'b000};
  assign half_lsb = {~r_off[1], 4'b0000};

  always_comb begin
    rd_byte     = bus.mem_read_data[byte_lsb +: 8];
    rd_half     = bus.mem_read_data[half_lsb +: 16];
    load_data   = bus.mem_read_data;
    store_merge = bus.mem_read_data;
    case (r_size)
      2'b00: begin
        load_data = {{24{r_signed & rd_byte[7]}}, rd_byte};
        store_merge[byte_lsb +: 8] = r_wlo[7:0];
      end
      2'b01: begin
        load_data = {{16{r_signed & rd_half[15]}}, rd_half};
        store_merge[half_lsb +: 16] = r_wlo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we             <= 1'b0;
      r_size           <= 2'b00;
      r_signed         <= 1'b0;
      r_off            <= 2'b00;
      r_wlo            <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      resp_rdata_q     <= '0;
      resp_err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we         <= bus.req_we;
            r_size       <= bus.req_size;
            r_signed     <= bus.req_signed;
            r_off        <= bus.req_addr[1:0];
            r_wlo        <= bus.req_wdata[15:0];
            mem_addr_q   <= {bus.req_addr[31:2], 2'b00};
            resp_err_q   <= req_bad;
            resp_rdata_q <= '0;
            if (!req_bad) begin
              if (bus.req_we && bus.req_size == 2'b10) begin
                mem_write_q      <= 1'b1;
                mem_write_data_q <= bus.req_wdata;
              end else begin
                mem_read_q <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (timeout) begin
            mem_read_q   <= 1'b0;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (bus.mem_ack) begin
            mem_read_q <= 1'b0;
            if (r_we) begin
              mem_write_q      <= 1'b1;
              mem_write_data_q <= store_merge;
            end else begin
              resp_rdata_q <= load_data;
            end
          end
        end
        WR: begin
          if (timeout) begin
            mem_write_q <= 1'b0;
            resp_err_q  <= 1'b1;
          end else if (bus.mem_ack) begin
            mem_write_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = ready_c;
  assign bus.resp_valid     = resp_valid_c;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl
// Self-checking bench for mem_req_ctrl: directed vector table, a reset
// mid-transaction sequence, and randomized transactions checked against a
// behavioural model. The bench also plays the SRAM IO controller, acking
// each strobe after a per-transaction latency (negative = never).
module tb_mem_req_ctrl;
  localparam int TC = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus();

  mem_req_ctrl #(.TIMEOUT_CYCLES(TC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_wdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int          o_rd, o_wr, o_lat;
  bit          o_overlap, o_got;
  logic [31:0] o_rdata, o_wdata, o_addr;
  logic        o_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic bit is_to(input int lat);
    return (lat < 0) || (lat >= TC - 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr);
    int unsigned off = addr % 4;
    logic [31:0] v;
    if (size == 2'd2) return w;
    if (size == 2'd0) begin
      v = (w >> ((3 - off) * 8)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> ((2 - off) * 8)) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] wd, input logic [31:0] addr);
    int unsigned off = addr % 4;
    int unsigned sh;
    logic [31:0] mask;
    if (size == 2'd2) return wd;
    sh   = (size == 2'd0) ? (3 - off) * 8 : (2 - off) * 8;
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic run_txn(input vec_t v);
    logic [1:0] kind, prev_kind;
    int age;
    bit done;
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    o_rd = 0; o_wr = 0; o_lat = 0; o_overlap = 0; o_got = 0;
    o_rdata = '0; o_wdata = '0; o_addr = '0; o_err = 1'b0;
    age = 0; prev_kind = 2'b00; done = 0;
    for (int c = 1; c <= 100 && !done; c++) begin
      if (bus.mem_read && bus.mem_write) o_overlap = 1;
      kind = {bus.mem_write, bus.mem_read};
      if (bus.resp_valid) begin
        o_got = 1; o_lat = c; o_rdata = bus.resp_rdata; o_err = bus.resp_err;
        bus.mem_ack = 1'b0;
        done = 1;
      end else begin
        if (kind != 2'b00) begin
          if (kind != prev_kind) age = 0;
          o_addr = bus.mem_addr;
          if (bus.mem_read)  o_rd++;
          if (bus.mem_write) o_wr++;
          bus.mem_read_data = v.mword;
          bus.mem_ack = (v.lat >= 0 && age == v.lat);
          if (bus.mem_ack && bus.mem_write) o_wdata = bus.mem_write_data;
          age++;
        end else begin
          bus.mem_ack = 1'b0;
        end
        prev_kind = kind;
        @(posedge clk); #1;
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int e_rd, e_wr, e_lat;
    bit bad, to;
    bad = is_bad(v.size, v.addr);
    to  = is_to(v.lat);
    if (bad) begin
      e_rd = 0; e_wr = 0; e_lat = 1;
    end else if (to) begin
      if (v.we && v.size == 2'd2) begin e_rd = 0; e_wr = TC; end
      else begin e_rd = TC; e_wr = 0; end
      e_lat = TC + 1;
    end else if (!v.we) begin
      e_rd = v.lat + 1; e_wr = 0; e_lat = v.lat + 2;
    end else if (v.size == 2'd2) begin
      e_rd = 0; e_wr = v.lat + 1; e_lat = v.lat + 2;
    end else begin
      e_rd = v.lat + 1; e_wr = v.lat + 1; e_lat = 2 * v.lat + 3;
    end
    run_txn(v);
    chk({tag, " resp_seen"}, 32'(o_got), 32'd1);
    chk({tag, " err"}, 32'(o_err), 32'(v.exp_err));
    chk({tag, " rdata"}, o_rdata, v.exp_rdata);
    chk({tag, " read_cycles"}, o_rd, e_rd);
    chk({tag, " write_cycles"}, o_wr, e_wr);
    chk({tag, " latency"}, o_lat, e_lat);
    chk({tag, " overlap"}, 32'(o_overlap), 32'd0);
    if (e_rd + e_wr > 0) chk({tag, " mem_addr"}, o_addr, v.addr & 32'hFFFF_FFFC);
    if (e_wr > 0 && !to) chk({tag, " write_data"}, o_wdata, v.exp_wdata);
    @(posedge clk); #1;
    chk({tag, " pulse_one_cycle"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  vec_t tbl[14];
  vec_t rv;
  bit   seen;

  initial begin
    //          we    size   sgn   addr          wdata         mword         lat  rdata         err   wdata
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h1234_56F0, 1, 32'hFFFF_FFF0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h1234_56F0, 2, 32'h0000_00F0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h5555_AB12, 32'h1122_3344, 1, 32'h0,        1'b0, 32'h1122_AB12};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 32'h0,         1'b1, 32'h0};
    tbl[5]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,         1'b1, 32'h0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        2, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0,        32'h8001_7FFF, 0, 32'hFFFF_8001, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        32'h12A4_5678, 3, 32'h0000_00A4, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0401, 32'hFFFF_FF11, 32'hAABB_CCDD, 0, 32'h0,        1'b0, 32'hAA11_CCDD};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0,        32'h1111_1111, -1, 32'h0,        1'b1, 32'h0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'h0,        32'h2222_2222, TC - 1, 32'h0,    1'b1, 32'h0};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h0000_0203, 32'h0,        32'h0,        0, 32'h0,         1'b1, 32'h0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_0600, 32'h1234_5678, 32'h0,       -1, 32'h0,         1'b1, 32'h0};

    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_read_data = '0;
    #3;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_write_data", bus.mem_write_data, 32'h0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_and_check($sformatf("vec%0d", i), tbl[i]);

    // Reset while a load is waiting in RD.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_mid strobe_before", 32'(bus.mem_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid strobe_dropped", 32'(bus.mem_read), 32'd0);
    chk("rst_mid no_resp_in_reset", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.resp_valid || bus.mem_read || bus.mem_write) seen = 1;
      @(posedge clk); #1;
    end
    chk("rst_mid no_activity_after", 32'(seen), 32'd0);
    chk("rst_mid ready_after", 32'(bus.req_ready), 32'd1);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int r;
      a = $urandom();
      rv.we    = 1'($urandom_range(0, 1));
      r        = $urandom_range(0, 9);
      rv.size  = (r == 9) ? 2'd3 : 2'(r % 3);
      rv.sgn   = 1'($urandom_range(0, 1));
      rv.addr  = ($urandom_range(0, 3) == 0) ? a : ((a & 32'hFFFF_FFFC) | 32'(rv.size == 2'd0 ? a % 4 : (rv.size == 2'd1 ? (a % 2) * 2 : 0)));
      rv.wdata = $urandom();
      rv.mword = $urandom();
      r        = $urandom_range(0, 11);
      rv.lat   = (r > 9) ? -1 : r;
      rv.exp_err   = is_bad(rv.size, rv.addr) || is_to(rv.lat);
      rv.exp_rdata = (rv.exp_err || rv.we) ? 32'h0 : model_load(rv.mword, rv.size, rv.sgn, rv.addr);
      rv.exp_wdata = model_merge(rv.mword, rv.size, rv.wdata, rv.addr);
      run_and_check($sformatf("rnd%0d", n), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of cycles a bus strobe may wait for mem_ack before the request is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, core request valid.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_signed, input, 1, sign-extend sub-word load data.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, load result.
REQ-013 SHALL have port resp_err, output, 1, qualifies resp_valid; misaligned, illegal size or timeout.
REQ-014 SHALL have ports mem_read, output, 1, and mem_write, output, 1, bus strobes to the SRAM IO controller.
REQ-015 SHALL have port mem_ack, input, 1, one-cycle acknowledge from the IO controller.
REQ-016 SHALL have ports mem_addr, output, 32, and mem_write_data, output, 32, plus mem_read_data, input, 32.

Function
REQ-017 SHALL implement states IDLE, RD, WR and RESP; req_ready SHALL equal (state == IDLE).
REQ-018 SHALL latch all req_* fields on the edge where req_valid && req_ready.
REQ-019 SHALL check alignment at acceptance: half requires addr[0] = 0, word requires addr[1:0] = 0, and size 11 is illegal; a violating request SHALL go IDLE->RESP with resp_err = 1 and no bus strobe.
REQ-020 SHALL route a valid load or a byte/half store to RD, and a valid word store to WR.
REQ-021 SHALL drive all bus outputs from registers; mem_addr SHALL be {addr[31:2], 2'b00}.
REQ-022 SHALL assert mem_read (or mem_write) in the first cycle of RD (or WR) and hold it until mem_ack is sampled high.
REQ-023 SHALL deassert the strobe on the edge where mem_ack is sampled, so the controller sees it low on its next cycle and never restarts.
REQ-024 SHALL never assert mem_read and mem_write in the same cycle.
REQ-025 SHALL use big-endian byte lanes: offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; half offset 0 -> [31:16], 2 -> [15:0].
REQ-026 SHALL, on a load ack in RD, capture the selected lane right-aligned into resp_rdata, zero- or sign-extended per req_signed (word loads pass through), then go to RESP.
REQ-027 SHALL, on a sub-word store ack in RD, merge the low byte/half of req_wdata into the lane of the read word (read-modify-write) and go to WR with the merged word on mem_write_data.
REQ-028 SHALL, for a word store, drive req_wdata unchanged on mem_write_data; resp_rdata for stores SHALL be 0.
REQ-029 SHALL go to RESP on the mem_ack in WR.
REQ-030 SHALL count cycles in RD/WR with a counter cleared on state entry; when it reaches TIMEOUT_CYCLES without an ack, it SHALL drop the strobe and go to RESP with resp_err = 1 and resp_rdata = 0.
REQ-031 SHALL, in RESP, pulse resp_valid for exactly one cycle and return to IDLE; minimum load latency is acceptance to resp_valid = 2 cycles + controller latency.
REQ-032 SHALL ignore mem_ack outside RD/WR.
REQ-033 SHALL ignore an ack arriving in the same cycle the timeout fires (timeout wins).

Reset
REQ-034 SHALL, while reset = 0, force state IDLE, req_ready 1, and mem_read, mem_write, resp_valid and resp_err 0, with mem_addr, mem_write_data, resp_rdata and the counter all 0.
REQ-035 SHALL, on reset mid-transaction, drop strobes immediately and produce no response for the aborted request.

Verification
REQ-036 Word load addr 0x100, controller returns 0xDEADBEEF -> one mem_read burst at mem_addr 0x100, then resp_valid with rdata 0xDEADBEEF, err 0.
REQ-037 Signed byte load addr 0x103, read word 0x123456F0 -> rdata 0xFFFFFFF0; the unsigned form gives 0x000000F0.
REQ-038 Half store 0xAB12 to addr 0x202, memory word 0x11223344 -> read at 0x200 followed by write 0x1122AB12; the strobes never overlap.
REQ-039 Word load at addr 0x101, or size 11 -> no strobe; resp_valid with err 1 one cycle after acceptance.
REQ-040 No ack with TIMEOUT_CYCLES = 8 -> strobe held for 8 cycles, then dropped; resp err 1; a new request is accepted afterwards.
REQ-041 Reset asserted while in RD -> mem_read low asynchronously, no resp_valid, req_ready 1 after release.
